// File: rtl/demux1xn_slots_if.sv
// ---------------------------------------------------------------------------
// demux1xn_slots_if
//   Bundles the serial input side and the parallel lane output side of
//   demux1xn_slots. Clock and reset stay outside the interface.
//
//   Parameters:
//     DATA_W : width of one data word
//     LANES  : number of parallel output lanes (>= 2)
//
//   Signals:
//     data_in      [DATA_W]        serial input word
//     valid_in     [1]             qualifies data_in
//     sync         [1]             restart the frame with the current word in lane 0
//     data_out     [LANES*DATA_W]  lane k at bits [k*DATA_W +: DATA_W]
//     valid_out    [LANES]         valid bit per lane
//     frame_strobe [1]             one-cycle pulse when the lanes update
//     lane_idx     [IDX_W]         lane the current input word will be written to
//
//   Modports:
//     master : the stream source / lane consumer (drives the inputs)
//     slave  : the demux itself (drives the outputs)
// ---------------------------------------------------------------------------
interface demux1xn_slots_if #(
    parameter int DATA_W = 8,
    parameter int LANES  = 2
);
    localparam int IDX_W = $clog2(LANES);

    logic [DATA_W-1:0]       data_in;
    logic                    valid_in;
    logic                    sync;
    logic [LANES*DATA_W-1:0] data_out;
    logic [LANES-1:0]        valid_out;
    logic                    frame_strobe;
    logic [IDX_W-1:0]        lane_idx;

    modport master (
        output data_in,
        output valid_in,
        output sync,
        input  data_out,
        input  valid_out,
        input  frame_strobe,
        input  lane_idx
    );

    modport slave (
        input  data_in,
        input  valid_in,
        input  sync,
        output data_out,
        output valid_out,
        output frame_strobe,
        output lane_idx
    );
endinterface

// File: rtl/demux1xn_slots.sv
// ---------------------------------------------------------------------------
// demux1xn_slots
//   Serial-to-parallel demux. A stream of DATA_W-bit words (each with a
//   valid bit) is gathered into frames of LANES words; once per frame all
//   lanes are presented together on data_out/valid_out and frame_strobe
//   pulses for one cycle. Outputs then hold until the next frame.
//
//   Slot mode (PACKED=0): every cycle is a slot, valid or not.
//   Packed mode (PACKED=1): only valid words consume a lane; idle cycles
//   inside a frame are ignored.
//   sync restarts the frame with the current word in lane 0.
//
//   Ports:
//     clk_4f : input-rate clock, all logic on the rising edge
//     reset  : synchronous, active-high reset (wins over sync and valid_in)
//     bus    : demux1xn_slots_if.slave, see the interface for signal list
// ---------------------------------------------------------------------------
module demux1xn_slots #(
    parameter int DATA_W = 8,
    parameter int LANES  = 2,
    parameter int PACKED = 0
) (
    input  logic                  clk_4f,
    input  logic                  reset,
    demux1xn_slots_if.slave       bus
);
    localparam int               IDX_W    = $clog2(LANES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);
    localparam bit               PACKED_MODE = (PACKED != 32'sd0);

    // A single lane cannot form a frame; reject it at elaboration.
    generate
        if (LANES < 2) begin : g_lanes_check
            $error("demux1xn_slots: LANES must be at least 2");
        end
    endgenerate

    // Lane index of the word currently on data_in.
    logic [IDX_W-1:0]             lane_idx_r;
    logic [IDX_W-1:0]             lane_idx_s;

    // Capture buffer. Only lanes 0..LANES-2 need storage: the word in the
    // last lane is routed straight into the output registers.
    logic [LANES-2:0][DATA_W-1:0] buf_data_r;
    logic [LANES-2:0][DATA_W-1:0] buf_data_s;
    logic [LANES-2:0]             buf_valid_r;
    logic [LANES-2:0]             buf_valid_s;

    // Output registers, packed so that lane k lands on [k*DATA_W +: DATA_W].
    logic [LANES-1:0][DATA_W-1:0] data_out_r;
    logic [LANES-1:0][DATA_W-1:0] data_out_s;
    logic [LANES-1:0]             valid_out_r;
    logic [LANES-1:0]             valid_out_s;
    logic                         frame_strobe_r;
    logic                         frame_strobe_s;

    // High when the current cycle occupies a lane.
    logic                         take_s;

    // Next-state logic: buffer fill, lane index, frame completion, sync.
    always_comb begin
        lane_idx_s     = lane_idx_r;
        buf_data_s     = buf_data_r;
        buf_valid_s    = buf_valid_r;
        data_out_s     = data_out_r;
        valid_out_s    = valid_out_r;
        frame_strobe_s = 1'b0;

        if (PACKED_MODE) begin
            take_s = bus.valid_in;
        end else begin
            take_s = 1'b1;
        end

        if (bus.sync) begin
            // Restart the frame; outputs are left untouched and no strobe
            // is produced even if the old frame was one word from done.
            if (take_s) begin
                buf_data_s[0]  = bus.data_in;
                buf_valid_s[0] = bus.valid_in;
                lane_idx_s     = IDX_W'(1);
            end else begin
                lane_idx_s     = '0;
            end
        end else if (take_s) begin
            if (lane_idx_r == LAST_IDX) begin
                // Frame complete: stored lanes plus the current word.
                data_out_s     = {bus.data_in, buf_data_r};
                valid_out_s    = {bus.valid_in, buf_valid_r};
                frame_strobe_s = 1'b1;
                lane_idx_s     = '0;
            end else begin
                for (int k = 0; k < LANES - 1; k++) begin
                    if (lane_idx_r == IDX_W'(k)) begin
                        buf_data_s[k]  = bus.data_in;
                        buf_valid_s[k] = bus.valid_in;
                    end else begin
                        buf_data_s[k]  = buf_data_r[k];
                        buf_valid_s[k] = buf_valid_r[k];
                    end
                end
                lane_idx_s = lane_idx_r + IDX_W'(1);
            end
        end else begin
            // Packed-mode idle cycle: nothing moves.
            lane_idx_s = lane_idx_r;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_4f) begin
        if (reset) begin
            lane_idx_r     <= '0;
            buf_data_r     <= '0;
            buf_valid_r    <= '0;
            data_out_r     <= '0;
            valid_out_r    <= '0;
            frame_strobe_r <= 1'b0;
        end else begin
            lane_idx_r     <= lane_idx_s;
            buf_data_r     <= buf_data_s;
            buf_valid_r    <= buf_valid_s;
            data_out_r     <= data_out_s;
            valid_out_r    <= valid_out_s;
            frame_strobe_r <= frame_strobe_s;
        end
    end

    assign bus.data_out     = data_out_r;
    assign bus.valid_out    = valid_out_r;
    assign bus.frame_strobe = frame_strobe_r;
    assign bus.lane_idx     = lane_idx_r;

endmodule
